// File: rtl/instr_seq_mem.sv
// Writable instruction sequencer: holds DEPTH frames and streams the first prog_len of them
// to the ALU stage over valid/ready, with optional looping, abort, and an idle-time load port.
module instr_seq_mem #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    localparam int FRAME_W = 2 * DATA_W + 1 + OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [FRAME_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               loop_en,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] data_frame,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Handshake: a frame transfers on every rising edge where frame_valid and frame_ready are
    // both high; while frame_valid is high, data_frame and pc hold until that transfer.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [1:0]         state;
    logic [ADDR_W:0]    len;
    logic               loop_q;
    logic               idle_like;
    logic               last;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign last      = ({1'b0, pc} + LEN_ONE) == len;

    assign frame_valid = (state == PRESENT);
    assign busy        = (state == FETCH) || (state == PRESENT);
    assign done        = (state == DONE);
    assign dbg_state   = state;

    // Loading is locked out while a program runs so the stream never sees a torn update.
    always_ff @(posedge clk) begin
        if (wr_en && idle_like) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            len        <= '0;
            loop_q     <= 1'b0;
            data_frame <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len    <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        loop_q <= loop_en;
                        pc     <= '0;
                        state  <= (prog_len == '0) ? DONE : FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state <= IDLE;
                        pc    <= '0;
                    end else begin
                        data_frame <= mem[pc];
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    // stop wins over a same-cycle handshake; the frame still counts as taken.
                    if (stop) begin
                        state <= IDLE;
                        pc    <= '0;
                    end else if (frame_ready) begin
                        if (!last) begin
                            pc    <= pc + PC_ONE;
                            state <= FETCH;
                        end else if (loop_q) begin
                            pc    <= '0;
                            state <= FETCH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq_mem.sv
// Randomized bench for instr_seq_mem: a queue-based model of the expected frame stream is
// compared against every presented frame, with timing, abort and load-lockout scenarios.
module tb_instr_seq_mem;

    localparam int DATA_W = 4;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int FW     = 2 * DATA_W + 1 + OP_W;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [FW-1:0]     wr_data;
    logic              start;
    logic              stop;
    logic [ADDR_W:0]   prog_len;
    logic              loop_en;
    logic              frame_valid;
    logic              frame_ready;
    logic [FW-1:0]     data_frame;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    logic [FW-1:0] mem_model [DEPTH];
    logic [FW-1:0] exp_q [$];
    int vectors = 0;
    int errors  = 0;

    instr_seq_mem #(
        .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .prog_len(prog_len), .loop_en(loop_en),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .data_frame(data_frame),
        .pc(pc), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver: load one entry while idle and mirror it into the model.
    task automatic load(input int addr, input logic [FW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr[ADDR_W-1:0];
        wr_data = d;
        mem_model[addr] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Driver + scoreboard for one program run.
    // mode: 0 ready tied high, 1 random ready, 2 ready low 3 cycles on the second frame.
    // abort_kind: 0 none, 1 stop, 2 rst; asserted while presenting frame number abort_at.
    task automatic run_prog(input int plen, input bit lp, input int mode,
                            input int abort_at, input int abort_kind, input bit wr_busy);
        int n, hs, first_valid, last_hs, done_cyc, dones, stall, idx;
        bit rdy, finished, aborted;
        n = (plen > DEPTH) ? DEPTH : plen;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);
        hs = 0; first_valid = -1; last_hs = 0; done_cyc = -1; dones = 0; stall = 0;
        finished = 1'b0; aborted = 1'b0;
        @(negedge clk);
        prog_len    = plen[ADDR_W:0];
        loop_en     = lp;
        start       = 1'b1;
        frame_ready = 1'b1;
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; wr_en = 1'b0; rst = 1'b0;
            if (cyc == 1) begin
                prog_len = (ADDR_W + 1)'($urandom_range(0, 15));
                loop_en  = 1'($urandom_range(0, 1));
            end
            if (wr_busy && cyc == 3) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 13'h1FFF;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_width", done, 0);
                finished = 1'b1;
            end else if (done) begin
                dones++;
                done_cyc = cyc;
                if (n == 0) chk("len0_done_latency", cyc <= 2, 1);
                else chk("done_timing", cyc, last_hs + 1);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = !(frame_valid && hs == 1 && stall < 3);
            endcase
            if (mode == 2 && frame_valid && !rdy) begin
                stall++;
                start    = 1'b1;
                prog_len = (ADDR_W + 1)'($urandom_range(0, 15));
            end
            frame_ready = rdy;
            if (frame_valid && !finished) begin
                idx = n - exp_q.size();
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_frame", 1, 0);
                end else begin
                    chk("data_frame", data_frame, exp_q[0]);
                    chk("pc", pc, idx);
                end
                if (abort_kind != 0 && hs == abort_at) begin
                    frame_ready = 1'b1;
                    if (abort_kind == 1) stop = 1'b1;
                    else rst = 1'b1;
                    @(negedge clk);
                    stop = 1'b0; rst = 1'b0;
                    chk("abort_valid", frame_valid, 0);
                    chk("abort_state", dbg_state, ST_IDLE);
                    chk("abort_pc", pc, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    if (abort_kind == 2) chk("rst_data_frame", data_frame, 0);
                    chk("no_done_before_abort", dones, 0);
                    aborted = 1'b1;
                    finished = 1'b1;
                end else if (rdy) begin
                    if (mode == 0 && hs > 0) chk("throughput", cyc - last_hs, 2);
                    last_hs = cyc;
                    hs++;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0 && lp)
                        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);
                end
            end
        end
        frame_ready = 1'b0;
        if (!aborted) begin
            chk("completed", finished, 1);
            chk("frame_count", hs, n);
            chk("done_count", dones, 1);
            if (n > 0) chk("first_valid_latency", first_valid, 2);
            else chk("len0_no_valid", first_valid, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
        prog_len = '0; loop_en = 1'b0; frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", frame_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pc", pc, 0);
        chk("reset_data", data_frame, 0);
        chk("reset_state", dbg_state, ST_IDLE);

        load(0, 13'h0510); load(1, 13'h04E1); load(2, 13'h0861);
        load(3, 13'h1052); load(4, 13'h0F44); load(5, 13'h0307);
        load(6, FW'($urandom)); load(7, FW'($urandom));

        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("stop_in_idle", dbg_state, ST_IDLE);

        run_prog(6, 1'b0, 0, 0, 0, 1'b0);
        run_prog(6, 1'b0, 2, 0, 0, 1'b0);
        run_prog(2, 1'b1, 0, 5, 1, 1'b0);
        run_prog(0, 1'b0, 0, 0, 0, 1'b0);
        run_prog(15, 1'b0, 0, 0, 0, 1'b0);
        run_prog(6, 1'b0, 1, 0, 0, 1'b1);
        run_prog(3, 1'b0, 0, 0, 0, 1'b0);
        load(0, 13'h1FFF);
        run_prog(3, 1'b0, 1, 0, 0, 1'b0);
        load(0, 13'h0510);
        run_prog(6, 1'b0, 0, 3, 2, 1'b0);
        run_prog(6, 1'b0, 1, 0, 0, 1'b0);

        repeat (8) begin
            load($urandom_range(0, DEPTH - 1), FW'($urandom));
            run_prog($urandom_range(0, 15), 1'b0, 1, 0, 0, 1'($urandom_range(0, 1)));
        end
        run_prog($urandom_range(1, 8), 1'b1, 1, $urandom_range(3, 12), 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
